// File: rtl/digit_serial_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, signed or unsigned per operation.
// Latency 2..NDIG+1 cycles from start to done; start is ignored while busy, and no backpressure on results.
module digit_serial_comparator #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             found_q, found_d;
  logic             found_gt_q, found_gt_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             digit_ne, digit_gt;

  // Operands shift left each cycle, so the digit under test is always the top one.
  assign dig_a    = a_q[WIDTH-1 -: DIGIT];
  assign dig_b    = b_q[WIDTH-1 -: DIGIT];
  assign digit_ne = (dig_a != dig_b);
  assign digit_gt = (dig_a > dig_b);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    found_d    = found_q;
    found_gt_d = found_gt_q;
    done_d     = 1'b0;
    gt_d       = gt_q;
    lt_d       = lt_q;
    eq_d       = eq_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d = a;
          b_d = b;
          // Flipping the sign bit maps two's complement onto offset binary.
          if (signed_mode) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
          end
          k_d        = '0;
          found_d    = 1'b0;
          found_gt_d = 1'b0;
          state_d    = COMPARE;
        end
      end

      COMPARE: begin
        a_d = a_q << DIGIT;
        b_d = b_q << DIGIT;
        if (!found_q && digit_ne) begin
          found_d    = 1'b1;
          found_gt_d = digit_gt;
        end

        if (EARLY_EXIT && digit_ne) begin
          gt_d    = digit_gt;
          lt_d    = ~digit_gt;
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (k_q == KW'(NDIG - 1)) begin
          gt_d    = found_d & found_gt_d;
          lt_d    = found_d & ~found_gt_d;
          eq_d    = ~found_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      found_q    <= 1'b0;
      found_gt_q <= 1'b0;
      done_q     <= 1'b0;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      found_q    <= found_d;
      found_gt_q <= found_gt_d;
      done_q     <= done_d;
      gt_q       <= gt_d;
      lt_q       <= lt_d;
      eq_q       <= eq_d;
    end
  end

  assign busy = (state_q == COMPARE);
  assign done = done_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_digit_serial_comparator.sv
// Bench for digit_serial_comparator: early-exit and full-scan instances driven side by side.
module tb_digit_serial_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy1, done1, gt1, lt1, eq1;
  logic        busy0, done0, gt0, lt0, eq0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_serial_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1));

  digit_serial_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy0), .done(done0), .gt(gt0), .lt(lt0), .eq(eq0));

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        sm;
    logic [2:0]  res;   // {gt, lt, eq}
    int          lat1;
    int          lat0;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_res(input logic [15:0] x, input logic [15:0] y, input logic sm);
    if (sm) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b010;
      return 3'b001;
    end
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
    return 3'b001;
  endfunction

  // Early exit stops at the first differing nibble; the sign-bit flip hits both operands so
  // which nibble differs does not depend on the mode.
  function automatic int ref_lat_early(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] d;
    d = x ^ y;
    for (int i = 0; i < 4; i++)
      if (((d >> (12 - 4 * i)) & 16'hF) != 16'h0) return i + 2;
    return 5;
  endfunction

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic sm,
                       output int lat1, output int lat0, output int bsy1, output int bsy0,
                       output logic [2:0] r1, output logic [2:0] r0, output bit stable);
    logic [2:0] hold1, hold0;
    @(negedge clk);
    a = ta; b = tbv; signed_mode = sm; start1 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
    lat1 = 0; lat0 = 0; bsy1 = 0; bsy0 = 0; r1 = '0; r0 = '0; stable = 1'b1;
    hold1 = {gt1, lt1, eq1};
    hold0 = {gt0, lt0, eq0};
    for (int n = 1; n <= 12; n++) begin
      if (busy1) begin
        bsy1++;
        if ({gt1, lt1, eq1} !== hold1) stable = 1'b0;
      end
      if (busy0) begin
        bsy0++;
        if ({gt0, lt0, eq0} !== hold0) stable = 1'b0;
      end
      if (done1 && lat1 == 0) begin lat1 = n; r1 = {gt1, lt1, eq1}; end
      if (done0 && lat0 == 0) begin lat0 = n; r0 = {gt0, lt0, eq0}; end
      if (lat1 != 0 && lat0 != 0) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_done1(input int n0, output int lat, output logic [2:0] r);
    int n;
    n = n0; lat = 0; r = '0;
    while (lat == 0 && n < n0 + 12) begin
      if (done1) begin
        lat = n;
        r = {gt1, lt1, eq1};
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  initial begin
    vec_t        vecs[10];
    int          l1, l0, b1, b0, extra;
    logic [2:0]  r1, r0, exp_r;
    bit          st;
    logic [15:0] x, y;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b1, 3'b010, 2, 5};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 3'b100, 2, 5};
    vecs[2] = '{16'h1234, 16'h1234, 1'b0, 3'b001, 5, 5};
    vecs[3] = '{16'h1235, 16'h1234, 1'b0, 3'b100, 5, 5};
    vecs[4] = '{16'h1234, 16'h1235, 1'b0, 3'b010, 5, 5};
    vecs[5] = '{16'h8000, 16'h7FFF, 1'b1, 3'b010, 2, 5};
    vecs[6] = '{16'hF000, 16'h0000, 1'b0, 3'b100, 2, 5};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 3'b001, 5, 5};
    vecs[8] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 2, 5};
    vecs[9] = '{16'h1204, 16'h1234, 1'b1, 3'b010, 4, 5};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, busy1, done1, gt1, lt1, eq1}, 32'd0);
    chk("reset_outputs_full", {27'd0, busy0, done0, gt0, lt0, eq0}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].sm, l1, l0, b1, b0, r1, r0, st);
      chk($sformatf("vec%0d_res_early", i), {29'd0, r1}, {29'd0, vecs[i].res});
      chk($sformatf("vec%0d_lat_early", i), l1, vecs[i].lat1);
      chk($sformatf("vec%0d_busy_early", i), b1, vecs[i].lat1 - 1);
      chk($sformatf("vec%0d_res_full", i), {29'd0, r0}, {29'd0, vecs[i].res});
      chk($sformatf("vec%0d_lat_full", i), l0, vecs[i].lat0);
      chk($sformatf("vec%0d_busy_full", i), b0, vecs[i].lat0 - 1);
      chk($sformatf("vec%0d_stable", i), {31'd0, st}, 32'd1);
    end

    // start re-asserted while busy must be ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start1 = 1'b1;
    @(negedge clk);
    a = 16'h0000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done1(2, l1, r1);
    chk("ignored_start_lat", l1, 5);
    chk("ignored_start_res", {29'd0, r1}, 32'b001);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done1) extra++;
    end
    chk("ignored_start_no_extra_done", extra, 0);

    // start in the done cycle is accepted without a bubble
    @(negedge clk);
    a = 16'hF000; b = 16'h0000; signed_mode = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("b2b_first_done", {31'd0, done1}, 32'd1);
    chk("b2b_first_res", {29'd0, gt1, lt1, eq1}, 32'b100);
    a = 16'h0002; b = 16'h0001; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("b2b_second_busy", {31'd0, busy1}, 32'd1);
    wait_done1(3, l1, r1);
    chk("b2b_second_lat", l1, 7);
    chk("b2b_second_res", {29'd0, r1}, 32'b100);

    // reset in the middle of a compare
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start1 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_early", {27'd0, busy1, done1, gt1, lt1, eq1}, 32'd0);
    chk("midreset_full", {27'd0, busy0, done0, gt0, lt0, eq0}, 32'd0);
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done1 || done0) extra++;
    end
    chk("midreset_no_done", extra, 0);

    // random sweep, each pair in both modes
    for (int i = 0; i < 5000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 8 == 0) y = x;
      else if (i % 8 == 1) y = x ^ (16'h1 << $urandom_range(0, 15));
      for (int m = 0; m < 2; m++) begin
        do_op(x, y, m[0], l1, l0, b1, b0, r1, r0, st);
        exp_r = ref_res(x, y, m[0]);
        chk("rand_res_early", {29'd0, r1}, {29'd0, exp_r});
        chk("rand_res_full", {29'd0, r0}, {29'd0, exp_r});
        chk("rand_lat_early", l1, ref_lat_early(x, y));
        chk("rand_lat_full", l0, 5);
        chk("rand_busy_early", b1, ref_lat_early(x, y) - 1);
        chk("rand_busy_full", b0, 4);
        chk("rand_stable", {31'd0, st}, 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
